// File: rtl/mem_arbiter.sv
// Purpose: shares one downstream memory port between instruction port A and data port B.
// Latency: request seen in IDLE at edge N drives pmem_* from cycle N+1; resp is passed through combinationally.
// Backpressure: a requester holds its request until its resp; one IDLE cycle separates transactions.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_a,
  input  logic        mem_write_a,
  input  logic [1:0]  mem_wmask_a,
  input  logic [15:0] mem_address_a,
  input  logic [15:0] mem_wdata_a,
  output logic        mem_resp_a,
  output logic [15:0] mem_rdata_a,
  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [1:0]  mem_wmask_b,
  input  logic [15:0] mem_address_b,
  input  logic [15:0] mem_wdata_b,
  output logic        mem_resp_b,
  output logic [15:0] mem_rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [15:0] rdata_a_q;
  logic [15:0] rdata_b_q;

  logic req_a, req_b, starved, grant_a, grant_b;

  // B wins by default; A wins when B is idle or after LIMIT back-to-back B grants it sat through.
  always_comb begin
    req_a   = mem_read_a | mem_write_a;
    req_b   = mem_read_b | mem_write_b;
    starved = (starve_cnt == LIMIT);
    grant_a = req_a & (~req_b | starved);
    grant_b = req_b & ~grant_a;
  end

  // Completion is routed to the owning port in the same cycle the memory answers.
  always_comb begin
    mem_resp_a  = (state == SERVE_A) & pmem_resp;
    mem_resp_b  = (state == SERVE_B) & pmem_resp;
    mem_rdata_a = mem_resp_a ? pmem_rdata : rdata_a_q;
    mem_rdata_b = mem_resp_b ? pmem_rdata : rdata_b_q;
  end

  // Arbitration FSM: capture the winner's request into the pmem_* registers and hold it until resp.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wmask   <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a) begin
            state        <= SERVE_A;
            pmem_read    <= mem_read_a & ~mem_write_a;
            pmem_write   <= mem_write_a;
            pmem_wmask   <= mem_wmask_a;
            pmem_address <= mem_address_a;
            pmem_wdata   <= mem_wdata_a;
            starve_cnt   <= '0;
          end else if (grant_b) begin
            state        <= SERVE_B;
            pmem_read    <= mem_read_b & ~mem_write_b;
            pmem_write   <= mem_write_b;
            pmem_wmask   <= mem_wmask_b;
            pmem_address <= mem_address_b;
            pmem_wdata   <= mem_wdata_b;
            if (!req_a)       starve_cnt <= '0;
            else if (!starved) starve_cnt <= starve_cnt + 4'd1;
          end
        end
        SERVE_A, SERVE_B: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Keep the last data returned to each port visible between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (mem_resp_a) rdata_a_q <= pmem_rdata;
      if (mem_resp_b) rdata_b_q <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: checks mem_arbiter against an ownership/priority reference model and a bench-side memory.
// Latency: memory answers after a programmable number of active cycles.
// Backpressure: requesters hold until their resp, then drop or re-request.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_a, mem_write_a, mem_read_b, mem_write_b;
  logic [1:0]  mem_wmask_a, mem_wmask_b;
  logic [15:0] mem_address_a, mem_wdata_a, mem_address_b, mem_wdata_b;
  logic        mem_resp_a, mem_resp_b;
  logic [15:0] mem_rdata_a, mem_rdata_b;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .mem_read_a(mem_read_a), .mem_write_a(mem_write_a), .mem_wmask_a(mem_wmask_a),
    .mem_address_a(mem_address_a), .mem_wdata_a(mem_wdata_a),
    .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b), .mem_wmask_b(mem_wmask_b),
    .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b),
    .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  // requester state, index 0 = port A, 1 = port B
  logic        rq_rd [2];
  logic        rq_wr [2];
  logic [1:0]  rq_mask [2];
  logic [15:0] rq_addr [2];
  logic [15:0] rq_wdata [2];
  bit          rq_keep [2];
  bit          rq_auto [2];
  int          rq_gap [2];

  assign mem_read_a = rq_rd[0];    assign mem_write_a = rq_wr[0];
  assign mem_wmask_a = rq_mask[0]; assign mem_address_a = rq_addr[0];
  assign mem_wdata_a = rq_wdata[0];
  assign mem_read_b = rq_rd[1];    assign mem_write_b = rq_wr[1];
  assign mem_wmask_b = rq_mask[1]; assign mem_address_b = rq_addr[1];
  assign mem_wdata_b = rq_wdata[1];

  // bench memory and responder controls
  logic [15:0] mem [256];
  int  lat_min, lat_max, cur_lat, busy_cnt;
  bit  resp_en, force_resp;

  // reference model: who owns the memory port (0 none, 1 A, 2 B)
  int          m_own, m_streak;
  logic [15:0] m_cap_addr, m_cap_wdata;
  logic [1:0]  m_cap_mask;
  logic        m_cap_wr;
  logic [15:0] m_last [2];
  bit          prev_resp;

  int n_vec, n_err, cyc, rd_cycles, resp_a_cnt, resp_b_cnt;
  int g_port [$];
  int g_cycle [$];

  function automatic int idx(input logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo; lat_max = hi; cur_lat = lo; busy_cnt = 0;
  endtask

  task automatic new_req(input int p);
    int op;
    op = int'($urandom_range(3, 0));
    rq_rd[p]    = (op != 1);
    rq_wr[p]    = (op == 1) || (op == 2);
    rq_mask[p]  = 2'($urandom);
    rq_addr[p]  = 16'($urandom);
    rq_wdata[p] = 16'($urandom);
  endtask

  task automatic tick();
    bit ra, rb, resp;
    int w, p;
    logic [15:0] rv, cur;
    @(posedge clk); #2; cyc++;
    // model advance, using the request levels that were present at this edge
    ra = rq_rd[0] | rq_wr[0];
    rb = rq_rd[1] | rq_wr[1];
    if (reset) begin
      m_own = 0; m_streak = 0; m_last[0] = '0; m_last[1] = '0;
    end else if (m_own == 0) begin
      if (ra || rb) begin
        w = (ra && (!rb || m_streak == LIMIT)) ? 1 : 2;
        if (w == 1) m_streak = 0;
        else m_streak = ra ? ((m_streak == LIMIT) ? LIMIT : m_streak + 1) : 0;
        m_own = w; p = w - 1;
        m_cap_addr = rq_addr[p]; m_cap_wdata = rq_wdata[p];
        m_cap_mask = rq_mask[p]; m_cap_wr = rq_wr[p];
        g_port.push_back(w); g_cycle.push_back(cyc);
      end
    end else if (prev_resp) begin
      m_own = 0;
    end
    chk("pmem_read", 32'(pmem_read), 32'(m_own != 0 && !m_cap_wr));
    chk("pmem_write", 32'(pmem_write), 32'(m_own != 0 && m_cap_wr));
    if (m_own != 0) begin
      chk("pmem_address", 32'(pmem_address), 32'(m_cap_addr));
      chk("pmem_wdata", 32'(pmem_wdata), 32'(m_cap_wdata));
      chk("pmem_wmask", 32'(pmem_wmask), 32'(m_cap_mask));
    end else if (reset) begin
      chk("rst_address", 32'(pmem_address), 32'h0);
      chk("rst_wdata", 32'(pmem_wdata), 32'h0);
      chk("rst_wmask", 32'(pmem_wmask), 32'h0);
    end
    if (pmem_read) rd_cycles++;
    // memory responder, reacting to what the DUT actually drives
    resp = 1'b0;
    rv = 16'($urandom);
    if (force_resp) resp = 1'b1;
    else if (resp_en && (pmem_read || pmem_write)) begin
      busy_cnt++;
      if (busy_cnt >= cur_lat) resp = 1'b1;
    end else busy_cnt = 0;
    if (resp && !force_resp) begin
      busy_cnt = 0;
      cur_lat = int'($urandom_range(lat_max, lat_min));
      if (pmem_read) rv = mem[idx(pmem_address)];
      if (pmem_write) begin
        cur = mem[idx(pmem_address)];
        if (pmem_wmask[0]) cur[7:0]  = pmem_wdata[7:0];
        if (pmem_wmask[1]) cur[15:8] = pmem_wdata[15:8];
        mem[idx(pmem_address)] = cur;
      end
    end
    pmem_resp  = resp;
    pmem_rdata = rv;
    if (resp && m_own != 0) m_last[m_own-1] = rv;
    if (resp && m_own == 1) resp_a_cnt++;
    if (resp && m_own == 2) resp_b_cnt++;
    prev_resp = resp;
    #1;
    chk("mem_resp_a", 32'(mem_resp_a), 32'(resp && m_own == 1));
    chk("mem_resp_b", 32'(mem_resp_b), 32'(resp && m_own == 2));
    chk("mem_rdata_a", 32'(mem_rdata_a), 32'(m_last[0]));
    chk("mem_rdata_b", 32'(mem_rdata_b), 32'(m_last[1]));
    // requesters: drop on own resp unless holding, auto ones re-request after a gap
    for (int q = 0; q < 2; q++) begin
      if (resp && m_own == q + 1 && !rq_keep[q]) begin
        rq_rd[q] = 1'b0; rq_wr[q] = 1'b0;
        rq_gap[q] = int'($urandom_range(3, 0));
      end
      if (rq_auto[q] && !(rq_rd[q] | rq_wr[q])) begin
        if (rq_gap[q] > 0) rq_gap[q]--;
        else new_req(q);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int nb;
    bit got_a;
    n_vec = 0; n_err = 0; cyc = 0; rd_cycles = 0; resp_a_cnt = 0; resp_b_cnt = 0;
    m_own = 0; m_streak = 0; m_last[0] = '0; m_last[1] = '0; prev_resp = 1'b0;
    m_cap_addr = '0; m_cap_wdata = '0; m_cap_mask = '0; m_cap_wr = 1'b0;
    for (int q = 0; q < 2; q++) begin
      rq_rd[q] = 1'b0; rq_wr[q] = 1'b0; rq_mask[q] = '0; rq_addr[q] = '0;
      rq_wdata[q] = '0; rq_keep[q] = 1'b0; rq_auto[q] = 1'b0; rq_gap[q] = 0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[idx(16'h1000)] = 16'h1234;
    pmem_resp = 1'b0; pmem_rdata = '0;
    resp_en = 1'b1; force_resp = 1'b0;
    set_lat(3, 3);

    // reset state
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    chk("reset_pmem_read", 32'(pmem_read), 32'h0);

    // A-only read of 0x1000, three-cycle memory
    rq_rd[0] = 1'b1; rq_addr[0] = 16'h1000;
    rd_cycles = 0; resp_a_cnt = 0;
    ticks(10);
    chk("t1_read_cycles", 32'(rd_cycles), 32'd3);
    chk("t1_resp_a_count", 32'(resp_a_cnt), 32'd1);
    chk("t1_rdata_a", 32'(mem_rdata_a), 32'h1234);

    // A and B together: B write first, then one idle cycle, then A
    set_lat(2, 2);
    g_port.delete(); g_cycle.delete();
    rq_rd[0] = 1'b1; rq_addr[0] = 16'h1000;
    rq_wr[1] = 1'b1; rq_addr[1] = 16'h2002; rq_wdata[1] = 16'hBEEF; rq_mask[1] = 2'b11;
    ticks(12);
    chk("t2_grants", 32'(g_port.size()), 32'd2);
    if (g_port.size() == 2) begin
      chk("t2_first_b", 32'(g_port[0]), 32'd2);
      chk("t2_second_a", 32'(g_port[1]), 32'd1);
      chk("t2_spacing", 32'(g_cycle[1] - g_cycle[0]), 32'd3);
    end
    chk("t2_mem_written", 32'(mem[idx(16'h2002)]), 32'hBEEF);
    chk("t2_rdata_a", 32'(mem_rdata_a), 32'h1234);

    // continuous B while A waits: LIMIT B grants, then A
    set_lat(1, 1);
    g_port.delete(); g_cycle.delete();
    rq_rd[1] = 1'b1; rq_addr[1] = 16'h2002; rq_keep[1] = 1'b1;
    rq_rd[0] = 1'b1; rq_addr[0] = 16'h1000;
    got_a = 1'b0;
    for (int i = 0; i < 60 && !got_a; i++) begin
      tick();
      foreach (g_port[k]) if (g_port[k] == 1) got_a = 1'b1;
    end
    nb = 0;
    foreach (g_port[k]) begin
      if (g_port[k] == 1) break;
      nb++;
    end
    chk("t3_a_granted", 32'(got_a), 32'd1);
    chk("t3_b_before_a", 32'(nb), 32'(LIMIT));
    rq_keep[1] = 1'b0;
    ticks(10);

    // B read+write together counts as a write, low byte only
    mem[idx(16'h3000)] = 16'h1234;
    rq_rd[1] = 1'b1; rq_wr[1] = 1'b1; rq_addr[1] = 16'h3000;
    rq_wdata[1] = 16'h5A5A; rq_mask[1] = 2'b01;
    ticks(8);
    chk("t4_masked_write", 32'(mem[idx(16'h3000)]), 32'h125A);

    // reset while B is in flight, stray resp right after reset
    resp_en = 1'b0;
    rq_rd[1] = 1'b1; rq_wr[1] = 1'b0; rq_addr[1] = 16'h2002;
    ticks(3);
    chk("t5_in_flight", 32'(pmem_read), 32'd1);
    reset = 1'b1; rq_rd[1] = 1'b0; force_resp = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_no_resp_b", 32'(mem_resp_b), 32'd0);
    chk("t5_pmem_read", 32'(pmem_read), 32'd0);
    chk("t5_pmem_address", 32'(pmem_address), 32'd0);
    force_resp = 1'b0; resp_en = 1'b1;
    ticks(3);

    // A address changes mid-transaction, captured address must hold
    set_lat(4, 4);
    rq_rd[0] = 1'b1; rq_addr[0] = 16'h1000;
    ticks(2);
    rq_addr[0] = 16'h0ABC;
    tick();
    chk("t6_addr_held", 32'(pmem_address), 32'h1000);
    ticks(8);

    // randomized traffic on both ports
    set_lat(1, 4);
    rq_auto[0] = 1'b1; rq_auto[1] = 1'b1;
    ticks(3000);
    rq_auto[0] = 1'b0; rq_auto[1] = 1'b0;
    ticks(30);
    chk("drain_idle", 32'(pmem_read | pmem_write), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
